abp_frame_serializer: RTL and testbench

Downstream stage of the ABP sender FSM. It accepts one (value, sequence bit) pair per handshake and serializes it into a fixed-length Ethernet frame on an AXI-Stream byte master. The frame carries a MAC header, the alternating bit, the big-endian value and zero padding. Its output feeds the MAC TX FIFO.

---
 rtl/abp_frame_serializer_pkg.sv | 49 ++++
 rtl/abp_frame_serializer_if.sv | 32 +++
 rtl/abp_frame_serializer.sv | 117 +++++++++++
 tb/tb_abp_frame_serializer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abp_frame_serializer_pkg.sv
// ABP shared definitions: frame layout, defaults, serializer state type
// and the frame byte selector shared with the deserializer.
package abp_pkg;

  localparam int unsigned ABP_DST_OFF   = 0;
  localparam int unsigned ABP_SRC_OFF   = 6;
  localparam int unsigned ABP_TYPE_OFF  = 12;
  localparam int unsigned ABP_BIT_OFF   = 14;
  localparam int unsigned ABP_VALUE_OFF = 15;
  localparam int unsigned ABP_HDR_LEN   = 15;

  localparam int unsigned ABP_MAX_VALUE_BYTES = 32;
  localparam int unsigned ABP_MAX_VALUE_BITS  = ABP_MAX_VALUE_BYTES * 8;

  localparam logic [15:0] ABP_DEF_ETHERTYPE = 16'h88B5;
  localparam logic [47:0] ABP_DEF_DST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] ABP_DEF_SRC_MAC   = 48'h0200_0000_0001;

  typedef enum logic {
    ABP_SER_IDLE = 1'b0,
    ABP_SER_SEND = 1'b1
  } abp_ser_state_e;

  // Byte at frame position idx; value is right-aligned, vbytes wide.
  function automatic logic [7:0] abp_frame_byte(
    input int unsigned                   idx,
    input logic [ABP_MAX_VALUE_BITS-1:0] value,
    input logic                          seq_bit,
    input int unsigned                   vbytes = 4,
    input logic [47:0]                   dst    = ABP_DEF_DST_MAC,
    input logic [47:0]                   src    = ABP_DEF_SRC_MAC,
    input logic [15:0]                   etype  = ABP_DEF_ETHERTYPE
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx < ABP_SRC_OFF)
      b = dst[8*(ABP_SRC_OFF-1-idx+ABP_DST_OFF) +: 8];
    else if (idx < ABP_TYPE_OFF)
      b = src[8*(ABP_TYPE_OFF-1-idx) +: 8];
    else if (idx < ABP_BIT_OFF)
      b = etype[8*(ABP_BIT_OFF-1-idx) +: 8];
    else if (idx == ABP_BIT_OFF)
      b = {7'b0, seq_bit};
    else if (idx < ABP_VALUE_OFF + vbytes)
      b = value[8*(ABP_VALUE_OFF+vbytes-1-idx) +: 8];
    return b;
  endfunction

endpackage

// File: rtl/abp_frame_serializer_if.sv
// Request handshake and AXI-Stream byte bus of the ABP serializer.
// slave is the serializer side, master the upstream/downstream side.
interface abp_frame_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VALUE_SIZE = 4
);
  import abp_pkg::*;

  logic                    s_abp_valid;
  logic                    s_abp_ready;
  logic [VALUE_SIZE*8-1:0] s_abp_value;
  logic                    s_abp_bit;
  logic                    m_axis_tvalid;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;

  modport slave (
    input  s_abp_valid, s_abp_value, s_abp_bit,
    input  m_axis_tready,
    output s_abp_ready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport master (
    output s_abp_valid, s_abp_value, s_abp_bit,
    output m_axis_tready,
    input  s_abp_ready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

endinterface

// File: rtl/abp_frame_serializer.sv
// ABP frame serializer: latches one (value, bit) request and emits a
// fixed-length Ethernet frame as registered AXI-Stream bytes.
module abp_frame_serializer
  import abp_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter int          VALUE_SIZE  = 4,
  parameter int          PACKET_SIZE = 64,
  parameter logic [47:0] DST_MAC     = ABP_DEF_DST_MAC,
  parameter logic [47:0] SRC_MAC     = ABP_DEF_SRC_MAC,
  parameter logic [15:0] ETHERTYPE   = ABP_DEF_ETHERTYPE
) (
  input  logic                   aclk,
  input  logic                   areset,
  abp_frame_serializer_if.slave  io,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  localparam int IDXW = $clog2(PACKET_SIZE);
  localparam int VW   = VALUE_SIZE * 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACKET_SIZE - 1);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("abp_frame_serializer: DATA_WIDTH must be 8");
  end
  if (PACKET_SIZE < int'(ABP_HDR_LEN) + VALUE_SIZE) begin : g_bad_size
    $error("abp_frame_serializer: PACKET_SIZE too small");
  end
  if (VALUE_SIZE < 1 || VALUE_SIZE > int'(ABP_MAX_VALUE_BYTES)) begin : g_bad_val
    $error("abp_frame_serializer: VALUE_SIZE out of range");
  end

  abp_ser_state_e  state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, idx_nxt;
  logic [VW-1:0]   value_q, value_d;
  logic            bit_q, bit_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic [15:0]     cnt_q, cnt_d;

  function automatic logic [7:0] sel_byte(
    input logic [IDXW-1:0] i,
    input logic [VW-1:0]   v,
    input logic            b
  );
    return abp_frame_byte(32'(i), ABP_MAX_VALUE_BITS'(v), b,
                          VALUE_SIZE, DST_MAC, SRC_MAC, ETHERTYPE);
  endfunction

  // Next state: accept in IDLE, advance one byte per accepted beat in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    bit_d   = bit_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    cnt_d   = cnt_q;
    idx_nxt = idx_q + IDXW'(1);
    unique case (state_q)
      ABP_SER_IDLE: begin
        if (io.s_abp_valid) begin
          state_d = ABP_SER_SEND;
          idx_d   = '0;
          value_d = io.s_abp_value;
          bit_d   = io.s_abp_bit;
          tdata_d = sel_byte('0, io.s_abp_value, io.s_abp_bit);
          tlast_d = 1'b0;
        end
      end
      ABP_SER_SEND: begin
        if (io.m_axis_tready) begin
          if (tlast_q) begin
            state_d = ABP_SER_IDLE;
            cnt_d   = cnt_q + 16'd1;
            tdata_d = 8'h00;
            tlast_d = 1'b0;
          end else begin
            idx_d   = idx_nxt;
            tdata_d = sel_byte(idx_nxt, value_q, bit_q);
            tlast_d = (idx_nxt == LAST_IDX);
          end
        end
      end
    endcase
  end

  // State and output registers; reset truncates any frame in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ABP_SER_IDLE;
      idx_q   <= '0;
      value_q <= '0;
      bit_q   <= 1'b0;
      tdata_q <= 8'h00;
      tlast_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      bit_q   <= bit_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy             = (state_q == ABP_SER_SEND);
  assign io.s_abp_ready   = (state_q == ABP_SER_IDLE);
  assign io.m_axis_tvalid = (state_q == ABP_SER_SEND);
  assign io.m_axis_tdata  = DATA_WIDTH'(tdata_q);
  assign io.m_axis_tlast  = tlast_q;
  assign frame_count      = cnt_q;

endmodule

// File: tb/tb_abp_frame_serializer.sv
// Self-checking bench for abp_frame_serializer: scoreboard of expected
// frame bytes built from hard-coded header constants.
module tb_abp_frame_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  abp_frame_serializer_if #(.DATA_WIDTH(8), .VALUE_SIZE(4)) bus ();
  abp_frame_serializer_if #(.DATA_WIDTH(8), .VALUE_SIZE(4)) bus19 ();

  logic        busy, busy19;
  logic [15:0] fcnt, fcnt19;

  abp_frame_serializer #(
    .DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(64)
  ) u_dut (
    .aclk(clk), .areset(rst), .io(bus),
    .busy(busy), .frame_count(fcnt)
  );

  abp_frame_serializer #(
    .DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(19)
  ) u_dut19 (
    .aclk(clk), .areset(rst), .io(bus19),
    .busy(busy19), .frame_count(fcnt19)
  );

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       l;
    logic       sr;
  } cyc_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  cyc_t  cyc_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void push_frame(input logic [31:0] val,
                                     input logic b, input int psize);
    logic [7:0] hdr [15];
    beat_t e;
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h88, 8'hB5, 8'h00};
    hdr[14] = {7'b0, b};
    for (int i = 0; i < psize; i++) begin
      if (i < 15)      e.d = hdr[i];
      else if (i < 19) e.d = val[8*(18-i) +: 8];
      else             e.d = 8'h00;
      e.l = (i == psize - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.s_abp_valid = 1'b0;   bus19.s_abp_valid = 1'b0;
    bus.s_abp_value = '0;     bus19.s_abp_value = '0;
    bus.s_abp_bit = 1'b0;     bus19.s_abp_bit = 1'b0;
    bus.m_axis_tready = 1'b1; bus19.m_axis_tready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_req(input int which, input logic [31:0] v,
                          input logic b);
    if (which == 0) begin
      bus.s_abp_valid = 1'b1; bus.s_abp_value = v; bus.s_abp_bit = b;
    end else begin
      bus19.s_abp_valid = 1'b1; bus19.s_abp_value = v; bus19.s_abp_bit = b;
    end
    @(negedge clk);
    bus.s_abp_valid = 1'b0;
    bus19.s_abp_valid = 1'b0;
  endtask

  // Records one cycle per negedge until the tlast handshake or budget.
  task automatic collect(input int which, input int budget,
                         input int stall_pct, output bit done);
    cyc_t c;
    logic rdy;
    cyc_q.delete();
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      rdy = ($urandom_range(0, 99) >= stall_pct);
      if (which == 0) bus.m_axis_tready = rdy;
      else            bus19.m_axis_tready = rdy;
      c.v  = which != 0 ? bus19.m_axis_tvalid : bus.m_axis_tvalid;
      c.d  = which != 0 ? bus19.m_axis_tdata  : bus.m_axis_tdata;
      c.l  = which != 0 ? bus19.m_axis_tlast  : bus.m_axis_tlast;
      c.sr = which != 0 ? bus19.s_abp_ready   : bus.s_abp_ready;
      c.r  = rdy;
      cyc_q.push_back(c);
      if (c.v && c.r && c.l) done = 1'b1;
      @(negedge clk);
    end
    bus.m_axis_tready = 1'b1;
    bus19.m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_abp_valid = 1'b1;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.s_abp_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready got %b want 1", bus.s_abp_ready); end
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_bad++;
      $display("FAIL rst_tvalid got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.m_axis_tlast !== 1'b0) begin n_bad++;
      $display("FAIL rst_tlast got %b want 0", bus.m_axis_tlast); end
    n_cmp++; if (bus.m_axis_tdata !== 8'h00) begin n_bad++;
      $display("FAIL rst_tdata got %h want 00", bus.m_axis_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (fcnt !== 16'd0) begin n_bad++;
      $display("FAIL rst_count got %0d want 0", fcnt); end
    bus.s_abp_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    push_frame(32'hDEADBEEF, 1'b1, 64);
    send_req(0, 32'hDEADBEEF, 1'b1);
    collect(0, 200, 0, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++;
      $display("FAIL basic_done got %b want 1", done); end
    nb = 0;
    foreach (cyc_q[i]) begin
      n_cmp++;
      if (!(cyc_q[i].v && cyc_q[i].r)) begin n_bad++;
        $display("FAIL basic_gap cyc %0d got v=%b want 1", i, cyc_q[i].v);
      end else if (exp_q.size() == 0) begin n_bad++;
        $display("FAIL basic_extra beat %0d got extra want none", nb);
      end else begin
        e = exp_q.pop_front();
        if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
          $display("FAIL basic_beat%0d got %h/%b want %h/%b",
                   nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
        end
      end
      nb++;
    end
    n_cmp++; if (nb != 64) begin n_bad++;
      $display("FAIL basic_len got %0d want 64", nb); end
    n_cmp++; if (fcnt !== 16'd1) begin n_bad++;
      $display("FAIL basic_count got %0d want 1", fcnt); end
    n_cmp++; if (bus.s_abp_ready !== 1'b1) begin n_bad++;
      $display("FAIL basic_ready got %b want 1", bus.s_abp_ready); end
  endtask

  task automatic test_backpressure();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    push_frame(32'hDEADBEEF, 1'b1, 64);
    send_req(0, 32'hDEADBEEF, 1'b1);
    collect(0, 600, 50, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++;
      $display("FAIL bp_done got %b want 1", done); end
    nb = 0;
    foreach (cyc_q[i]) begin
      n_cmp++;
      if (cyc_q[i].v !== 1'b1) begin n_bad++;
        $display("FAIL bp_tvalid cyc %0d got %b want 1", i, cyc_q[i].v);
      end
      if (i > 0 && cyc_q[i-1].v && !cyc_q[i-1].r) begin
        n_cmp++;
        if (cyc_q[i].d !== cyc_q[i-1].d || cyc_q[i].l !== cyc_q[i-1].l)
        begin n_bad++;
          $display("FAIL bp_hold cyc %0d got %h/%b want %h/%b", i,
                   cyc_q[i].d, cyc_q[i].l, cyc_q[i-1].d, cyc_q[i-1].l);
        end
      end
      if (cyc_q[i].v && cyc_q[i].r) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++;
          $display("FAIL bp_extra beat %0d got extra want none", nb);
        end else begin
          e = exp_q.pop_front();
          if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
            $display("FAIL bp_beat%0d got %h/%b want %h/%b",
                     nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
          end
        end
        nb++;
      end
    end
    n_cmp++; if (nb != 64) begin n_bad++;
      $display("FAIL bp_len got %0d want 64", nb); end
    n_cmp++; if (fcnt !== 16'd1) begin n_bad++;
      $display("FAIL bp_count got %0d want 1", fcnt); end
  endtask

  task automatic test_input_freeze();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    push_frame(32'h0000_0001, 1'b0, 64);
    bus.s_abp_valid = 1'b1;
    bus.s_abp_value = 32'h0000_0001;
    bus.s_abp_bit = 1'b0;
    @(negedge clk);
    bus.s_abp_valid = 1'b0;
    bus.s_abp_value = 32'hFFFF_FFFF;
    bus.s_abp_bit = 1'b1;
    collect(0, 200, 0, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++;
      $display("FAIL frz_done got %b want 1", done); end
    nb = 0;
    foreach (cyc_q[i]) begin
      n_cmp++;
      if (cyc_q[i].sr !== 1'b0) begin n_bad++;
        $display("FAIL frz_ready cyc %0d got %b want 0", i, cyc_q[i].sr);
      end
      if (cyc_q[i].v && cyc_q[i].r) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++;
          $display("FAIL frz_extra beat %0d got extra want none", nb);
        end else begin
          e = exp_q.pop_front();
          if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
            $display("FAIL frz_beat%0d got %h/%b want %h/%b",
                     nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
          end
        end
        nb++;
      end
    end
    n_cmp++; if (nb != 64) begin n_bad++;
      $display("FAIL frz_len got %0d want 64", nb); end
  endtask

  task automatic test_back_to_back();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    push_frame(32'd5, 1'b0, 64);
    push_frame(32'd6, 1'b1, 64);
    bus.s_abp_valid = 1'b1;
    bus.s_abp_value = 32'd5;
    bus.s_abp_bit = 1'b0;
    @(negedge clk);
    bus.s_abp_value = 32'd6;
    bus.s_abp_bit = 1'b1;
    for (int f = 0; f < 2; f++) begin
      collect(0, 200, 0, done);
      n_cmp++; if (done !== 1'b1) begin n_bad++;
        $display("FAIL b2b_done%0d got %b want 1", f, done); end
      nb = 0;
      foreach (cyc_q[i]) begin
        n_cmp++;
        if (!(cyc_q[i].v && cyc_q[i].r)) begin n_bad++;
          $display("FAIL b2b_gap%0d cyc %0d got v=%b want 1",
                   f, i, cyc_q[i].v);
        end else if (exp_q.size() == 0) begin n_bad++;
          $display("FAIL b2b_extra%0d got extra want none", f);
        end else begin
          e = exp_q.pop_front();
          if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
            $display("FAIL b2b_f%0d_beat%0d got %h/%b want %h/%b",
                     f, nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
          end
        end
        nb++;
      end
      n_cmp++; if (nb != 64) begin n_bad++;
        $display("FAIL b2b_len%0d got %0d want 64", f, nb); end
      if (f == 0) begin
        n_cmp++; if (bus.s_abp_ready !== 1'b1 || bus.m_axis_tvalid !== 1'b0)
        begin n_bad++;
          $display("FAIL b2b_gap_cycle got rdy=%b v=%b want 1/0",
                   bus.s_abp_ready, bus.m_axis_tvalid);
        end
        n_cmp++; if (fcnt !== 16'd1) begin n_bad++;
          $display("FAIL b2b_count1 got %0d want 1", fcnt); end
        @(negedge clk);
        bus.s_abp_valid = 1'b0;
      end
    end
    n_cmp++; if (fcnt !== 16'd2) begin n_bad++;
      $display("FAIL b2b_count2 got %0d want 2", fcnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    send_req(0, 32'hDEADBEEF, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.m_axis_tvalid !== 1'b1) begin n_bad++;
      $display("FAIL mid_active got %b want 1", bus.m_axis_tvalid); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_bad++;
      $display("FAIL mid_tvalid got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.s_abp_ready !== 1'b1) begin n_bad++;
      $display("FAIL mid_ready got %b want 1", bus.s_abp_ready); end
    n_cmp++; if (fcnt !== 16'd0) begin n_bad++;
      $display("FAIL mid_count got %0d want 0", fcnt); end
    n_cmp++; if (bus.m_axis_tlast !== 1'b0) begin n_bad++;
      $display("FAIL mid_tlast got %b want 0", bus.m_axis_tlast); end
    rst = 1'b0;
    @(negedge clk);
    push_frame(32'h1234_5678, 1'b0, 64);
    send_req(0, 32'h1234_5678, 1'b0);
    collect(0, 200, 0, done);
    n_cmp++; if (done !== 1'b1) begin n_bad++;
      $display("FAIL mid_done got %b want 1", done); end
    nb = 0;
    foreach (cyc_q[i]) begin
      n_cmp++;
      if (!(cyc_q[i].v && cyc_q[i].r)) begin n_bad++;
        $display("FAIL mid_gap cyc %0d got v=%b want 1", i, cyc_q[i].v);
      end else if (exp_q.size() == 0) begin n_bad++;
        $display("FAIL mid_extra got extra want none");
      end else begin
        e = exp_q.pop_front();
        if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
          $display("FAIL mid_beat%0d got %h/%b want %h/%b",
                   nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
        end
      end
      nb++;
    end
    n_cmp++; if (fcnt !== 16'd1) begin n_bad++;
      $display("FAIL mid_count_after got %0d want 1", fcnt); end
  endtask

  task automatic test_counter_wrap();
    bit done;
    beat_t e;
    int nb;
    do_reset();
    force u_dut19.cnt_q = 16'hFFFE;
    @(negedge clk);
    release u_dut19.cnt_q;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      push_frame(32'hA5C3_0F01 + 32'(f), 1'(f), 19);
      send_req(1, 32'hA5C3_0F01 + 32'(f), 1'(f));
      collect(1, 100, 0, done);
      n_cmp++; if (done !== 1'b1) begin n_bad++;
        $display("FAIL wrap_done%0d got %b want 1", f, done); end
      nb = 0;
      foreach (cyc_q[i]) begin
        n_cmp++;
        if (!(cyc_q[i].v && cyc_q[i].r)) begin n_bad++;
          $display("FAIL wrap_gap cyc %0d got v=%b want 1", i, cyc_q[i].v);
        end else if (exp_q.size() == 0) begin n_bad++;
          $display("FAIL wrap_extra got extra want none");
        end else begin
          e = exp_q.pop_front();
          if (cyc_q[i].d !== e.d || cyc_q[i].l !== e.l) begin n_bad++;
            $display("FAIL wrap_f%0d_beat%0d got %h/%b want %h/%b",
                     f, nb, cyc_q[i].d, cyc_q[i].l, e.d, e.l);
          end
        end
        nb++;
      end
      n_cmp++; if (nb != 19) begin n_bad++;
        $display("FAIL wrap_len%0d got %0d want 19", f, nb); end
      n_cmp++;
      if (fcnt19 !== (f == 0 ? 16'hFFFF : 16'h0000)) begin n_bad++;
        $display("FAIL wrap_count%0d got %h want %h", f, fcnt19,
                 (f == 0 ? 16'hFFFF : 16'h0000));
      end
    end
  endtask

  initial begin
    bus.s_abp_valid = 1'b0;   bus19.s_abp_valid = 1'b0;
    bus.s_abp_value = '0;     bus19.s_abp_value = '0;
    bus.s_abp_bit = 1'b0;     bus19.s_abp_bit = 1'b0;
    bus.m_axis_tready = 1'b1; bus19.m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_input_freeze();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
